// File: rtl/ascon_bloc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ascon_bloc_feeder
// Description : Block-level input sequencer for the ASCON-128 datapath.
//               Buffers host blocks in a 2-entry FIFO, presents them one at a
//               time to the permutation core with a last-block tag, and drives
//               the shared block counter so that it always equals the index of
//               the block currently presented.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_bloc_feeder #(
    parameter int DATA_W   = 64,
    parameter int MAX_BLOC = 4
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              last_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] bloc_o,
    output logic              bloc_valid_o,
    output logic              bloc_last_o,
    input  logic              bloc_ack_i,
    output logic              cpt_en_o,
    output logic              cpt_init_o,
    output logic              done_o,
    output logic              err_o
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Beat-count landmarks: index of the final allowed block, and saturation value
    localparam logic [2:0] C_BEAT_LAST = 3'(MAX_BLOC - 1);
    localparam logic [2:0] C_BEAT_MAX  = 3'(MAX_BLOC);

    // Registered state
    logic [1:0]        state_q,   state_d;
    logic [1:0]        occ_q,     occ_d;
    logic              rd_ptr_q,  rd_ptr_d;
    logic              wr_ptr_q,  wr_ptr_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic [1:0]        tag_q,     tag_d;
    logic [2:0]        beat_q,    beat_d;
    logic              tag_acc_q, tag_acc_d;
    logic              err_q,     err_d;
    logic              done_q,    done_d;

    // Handshake decode
    logic              flush;
    logic              push;
    logic              pop;
    logic              head_tag;
    logic              push_tag;

    // Handshake decode: a start outside INIT flushes and overrides any transfer
    always_comb begin
        flush        = start_i && (state_q != ST_INIT);
        data_ready_o = (state_q == ST_RUN) && (occ_q != 2'd2) && !tag_acc_q;
        bloc_valid_o = (occ_q != 2'd0);
        head_tag     = tag_q[rd_ptr_q];
        push         = data_valid_i && data_ready_o && !flush;
        pop          = bloc_ack_i && bloc_valid_o && !flush;
        push_tag     = last_i || (beat_q == C_BEAT_LAST);
    end

    // Core-side outputs: FIFO head, forced to zero when the FIFO is empty
    always_comb begin
        bloc_o      = '0;
        bloc_last_o = 1'b0;
        if (bloc_valid_o) begin
            bloc_o      = mem_q[rd_ptr_q];
            bloc_last_o = head_tag;
        end
    end

    // Counter drive: init pulse in INIT, increment on every untagged pop
    always_comb begin
        cpt_init_o = (state_q == ST_INIT);
        cpt_en_o   = (state_q == ST_INIT) || (pop && !head_tag);
        done_o     = done_q;
        err_o      = err_q;
    end

    // Next-state logic for the FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_INIT;
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_INIT;
                end else if (pop && head_tag) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-state logic for FIFO, beat count and status flags
    always_comb begin
        occ_d     = occ_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_d     = mem_q;
        tag_d     = tag_q;
        beat_d    = beat_q;
        tag_acc_d = tag_acc_q;
        err_d     = err_q;
        done_d    = 1'b0;

        if (flush) begin
            occ_d     = 2'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            tag_d     = 2'b00;
            beat_d    = 3'd0;
            tag_acc_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_i;
                tag_d[wr_ptr_q] = push_tag;
                wr_ptr_d        = ~wr_ptr_q;
                if (beat_q != C_BEAT_MAX) begin
                    beat_d = beat_q + 3'd1;
                end
                if (push_tag) begin
                    tag_acc_d = 1'b1;
                end
                // Block MAX_BLOC arrived without the host marking it last
                if (!last_i && (beat_q == C_BEAT_LAST)) begin
                    err_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                done_d   = head_tag;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= ST_IDLE;
            occ_q     <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            tag_q     <= 2'b00;
            beat_q    <= 3'd0;
            tag_acc_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            tag_acc_q <= tag_acc_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_bloc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_bloc_feeder
// Description : Scoreboard testbench for ascon_bloc_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_bloc_feeder;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
        logic [31:0] idx;
    } exp_t;

    logic        clk;
    logic        resetb;
    logic        start_i;
    logic [63:0] data_i;
    logic        data_valid_i;
    logic        last_i;
    logic        data_ready_o;
    logic [63:0] bloc_o;
    logic        bloc_valid_o;
    logic        bloc_last_o;
    logic        bloc_ack_i;
    logic        cpt_en_o;
    logic        cpt_init_o;
    logic        done_o;
    logic        err_o;

    int          n_cmp;
    int          n_fail;
    int          en_cnt;
    int          done_cnt;
    logic [31:0] cnt_model;
    exp_t        sb[$];

    ascon_bloc_feeder #(.DATA_W(64), .MAX_BLOC(4)) dut (
        .clock_i      (clk),
        .resetb_i     (resetb),
        .start_i      (start_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .last_i       (last_i),
        .data_ready_o (data_ready_o),
        .bloc_o       (bloc_o),
        .bloc_valid_o (bloc_valid_o),
        .bloc_last_o  (bloc_last_o),
        .bloc_ack_i   (bloc_ack_i),
        .cpt_en_o     (cpt_en_o),
        .cpt_init_o   (cpt_init_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the external 2-bit block counter driven by cpt_en/cpt_init
    always @(posedge clk) begin
        if (cpt_en_o) cnt_model <= cpt_init_o ? 32'd0 : cnt_model + 32'd1;
    end

    // Pulse counters for counter-increment and done events
    always @(negedge clk) begin
        if (resetb && cpt_en_o && !cpt_init_o) en_cnt++;
        if (resetb && done_o) done_cnt++;
    end

    // Monitor: each core-side pop is checked against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (resetb && bloc_valid_o && bloc_ack_i && !start_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pop actual=%h required=none", bloc_o);
            end else begin
                e = sb.pop_front();
                check("bloc_data", bloc_o, e.d);
                check("bloc_last", {63'd0, bloc_last_o}, {63'd0, e.last});
                check("cnt_index", {32'd0, cnt_model}, {32'd0, e.idx});
                check("cpt_en_on_pop", {63'd0, cpt_en_o}, {63'd0, !e.last});
            end
        end
    end

    task automatic do_start();
        start_i = 1'b1;
        sb.delete();
        tick();
        start_i = 1'b0;
        check("init_en",     {63'd0, cpt_en_o},     64'd1);
        check("init_init",   {63'd0, cpt_init_o},   64'd1);
        check("init_valid",  {63'd0, bloc_valid_o}, 64'd0);
        check("init_err",    {63'd0, err_o},        64'd0);
        tick();
        check("run_ready",   {63'd0, data_ready_o}, 64'd1);
    endtask

    task automatic send(input logic [63:0] d, input logic l, input int idx);
        logic ok;
        exp_t e;
        ok           = 1'b0;
        data_i       = d;
        last_i       = l;
        data_valid_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (data_ready_o) begin
                ok     = 1'b1;
                e.d    = d;
                e.last = l | (idx == 3);
                e.idx  = idx;
                sb.push_back(e);
            end
            tick();
            if (ok) break;
        end
        data_valid_i = 1'b0;
        last_i       = 1'b0;
        check("send_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 40; t++) begin
            if (done_cnt != 0) break;
            tick();
        end
        check("done_seen", {63'd0, (done_cnt != 0)}, 64'd1);
        repeat (3) tick();
    endtask

    initial begin
        logic ever_ready;
        n_cmp = 0; n_fail = 0; en_cnt = 0; done_cnt = 0; cnt_model = 0;
        resetb = 1'b0; start_i = 0; data_i = '0; data_valid_i = 0;
        last_i = 0; bloc_ack_i = 0;
        repeat (3) tick();
        check("rst_ready", {63'd0, data_ready_o}, 64'd0);
        check("rst_bloc",  bloc_o, 64'd0);
        check("rst_valid", {63'd0, bloc_valid_o}, 64'd0);
        check("rst_flags", {59'd0, bloc_last_o, cpt_en_o, cpt_init_o, done_o, err_o}, 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        repeat (2) tick();
        check("idle_ready", {63'd0, data_ready_o}, 64'd0);

        // Nominal 3-block message with the core always acknowledging
        bloc_ack_i = 1'b1;
        do_start();
        en_cnt = 0; done_cnt = 0;
        send(64'hAAAA_0000_1111_0000, 1'b0, 0);
        send(64'hBBBB_0000_2222_0000, 1'b0, 1);
        send(64'hCCCC_0000_3333_0000, 1'b1, 2);
        wait_done();
        check("nom_en_pulses", 64'(en_cnt),   64'd2);
        check("nom_done",      64'(done_cnt), 64'd1);
        check("nom_err",       {63'd0, err_o}, 64'd0);
        check("nom_idle",      {63'd0, data_ready_o}, 64'd0);
        check("nom_sb_empty",  64'(sb.size()), 64'd0);

        // Backpressure: FIFO fills at two entries
        bloc_ack_i = 1'b0;
        do_start();
        en_cnt = 0; done_cnt = 0;
        send(64'h1111_2222_3333_4444, 1'b0, 0);
        send(64'h5555_6666_7777_8888, 1'b0, 1);
        check("bp_ready_full", {63'd0, data_ready_o}, 64'd0);
        data_i = 64'h9999_AAAA_BBBB_CCCC; last_i = 1'b1; data_valid_i = 1'b1;
        ever_ready = 1'b0;
        repeat (3) begin
            tick();
            ever_ready = ever_ready | data_ready_o;
        end
        check("bp_hold", {63'd0, ever_ready}, 64'd0);
        bloc_ack_i = 1'b1;
        tick();
        bloc_ack_i = 1'b0;
        check("bp_ready_after_pop", {63'd0, data_ready_o}, 64'd1);
        send(64'h9999_AAAA_BBBB_CCCC, 1'b1, 2);
        bloc_ack_i = 1'b1;
        wait_done();
        check("bp_done", 64'(done_cnt), 64'd1);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow: four blocks without last_i
        bloc_ack_i = 1'b1;
        do_start();
        en_cnt = 0; done_cnt = 0;
        send(64'h0000_0000_0000_0010, 1'b0, 0);
        send(64'h0000_0000_0000_0020, 1'b0, 1);
        send(64'h0000_0000_0000_0030, 1'b0, 2);
        check("ovf_err_before", {63'd0, err_o}, 64'd0);
        send(64'h0000_0000_0000_0040, 1'b0, 3);
        check("ovf_err_after", {63'd0, err_o}, 64'd1);
        data_i = 64'h0000_0000_0000_0050; data_valid_i = 1'b1;
        ever_ready = data_ready_o;
        repeat (6) begin
            tick();
            ever_ready = ever_ready | data_ready_o;
        end
        data_valid_i = 1'b0;
        check("ovf_no_fifth", {63'd0, ever_ready}, 64'd0);
        check("ovf_done",  64'(done_cnt), 64'd1);
        check("ovf_en",    64'(en_cnt),   64'd3);
        check("ovf_err_idle", {63'd0, err_o}, 64'd1);

        // Restart mid-message with two blocks buffered
        bloc_ack_i = 1'b0;
        do_start();
        send(64'hDEAD_0000_0000_0001, 1'b0, 0);
        send(64'hDEAD_0000_0000_0002, 1'b0, 1);
        check("rs_ready_full", {63'd0, data_ready_o}, 64'd0);
        done_cnt = 0;
        do_start();
        send(64'hFEED_0000_0000_0003, 1'b1, 0);
        bloc_ack_i = 1'b1;
        wait_done();
        check("rs_done", 64'(done_cnt), 64'd1);
        check("rs_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset with one block buffered in RUN
        bloc_ack_i = 1'b0;
        do_start();
        send(64'h0BAD_0000_0000_0004, 1'b1, 0);
        check("ar_valid_pre", {63'd0, bloc_valid_o}, 64'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("ar_valid", {63'd0, bloc_valid_o}, 64'd0);
        check("ar_bloc",  bloc_o, 64'd0);
        check("ar_flags", {58'd0, data_ready_o, bloc_last_o, cpt_en_o, cpt_init_o, done_o, err_o}, 64'd0);
        sb.delete();
        @(negedge clk);
        resetb = 1'b1;
        en_cnt = 0;
        bloc_ack_i = 1'b1;
        repeat (3) tick();
        check("ar_idle_ready", {63'd0, data_ready_o}, 64'd0);
        check("ar_idle_valid", {63'd0, bloc_valid_o}, 64'd0);
        check("ar_no_en", 64'(en_cnt), 64'd0);

        // Stray ack with an empty FIFO in RUN
        do_start();
        en_cnt = 0; done_cnt = 0;
        repeat (4) tick();
        check("stray_en", 64'(en_cnt), 64'd0);
        check("stray_ready", {63'd0, data_ready_o}, 64'd1);
        send(64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 0);
        wait_done();
        check("stray_done", 64'(done_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ascon_bloc_feeder.md
# ascon_bloc_feeder

Block-level input sequencer for the ASCON-128 datapath. It accepts 64-bit data blocks from the host over a valid/ready handshake and buffers them in a 2-entry FIFO. It presents them one at a time to the permutation core with a last-block tag. It also drives the enable/init inputs of the shared 2-bit block counter, so the counter value always equals the index of the block currently presented to the core.

## Interface
Parameters:
- DATA_W, 64, block width in bits
- MAX_BLOC, 4, maximum blocks per message (matches the 2-bit block counter range)

Ports:
- clock_i  in  1  system clock; the block has one clock
- resetb_i  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle pulse; begins a new message and flushes any message in progress
- data_i  in  DATA_W  host block data
- data_valid_i  in  1  host block valid
- last_i  in  1  host marks final block of message
- data_ready_o  out  1  feeder can accept a host block this cycle
- bloc_o  out  DATA_W  block presented to core (FIFO head)
- bloc_valid_o  out  1  bloc_o holds a valid block
- bloc_last_o  out  1  presented block is the message's last
- bloc_ack_i  in  1  core consumes presented block
- cpt_en_o  out  1  block counter enable
- cpt_init_o  out  1  block counter init (valid only together with cpt_en_o)
- done_o  out  1  one-cycle pulse after last block consumed
- err_o  out  1  sticky: MAX_BLOC blocks received without last_i

## Operation
- FSM states: IDLE, INIT, RUN.
  - IDLE -> INIT on start_i.
  - INIT lasts exactly one cycle, with cpt_en_o=1 and cpt_init_o=1, then -> RUN.
  - RUN -> IDLE when the popped block carries the last tag.
  - start_i in any state other than INIT -> INIT. This flushes the FIFO, clears the beat count and clears err_o.
- Host accept: a transfer occurs when data_valid_i & data_ready_o. The block is pushed with tag = last_i | (beat count == MAX_BLOC-1).
- Beat count is 3 bits. It increments on each accepted transfer and saturates at MAX_BLOC.
- After a tagged block is accepted, no further transfers are accepted until the next start_i.
- If block MAX_BLOC is accepted with last_i=0, err_o is set. The block is still tagged last.
- Core side:
  - bloc_valid_o = (FIFO occupancy != 0).
  - bloc_o and bloc_last_o come from the FIFO head and are 0 when the FIFO is empty.
  - A pop occurs when bloc_ack_i & bloc_valid_o. bloc_ack_i while the FIFO is empty is ignored.
- Counter drive: each pop whose tag is 0 pulses cpt_en_o=1 with cpt_init_o=0 in the same cycle. A pop of the tagged block does not pulse the counter.
  - As a result, the counter reads 0 for block 0, 1 for block 1, and so on, and never wraps within a message.
- Pop of the tagged block: done_o=1 in the next cycle, and the state -> IDLE.
- data_ready_o = (state==RUN) & (occupancy < 2) & !tag_accepted.
  - It is a function of registered state only; there is no combinational path from data_valid_i or bloc_ack_i.
- Push and pop in the same cycle with occupancy 1: both take effect and occupancy stays 1. With occupancy 2, no push is possible.

## Timing
- Reset values: data_ready_o=0, bloc_o=0, bloc_valid_o=0, bloc_last_o=0, cpt_en_o=0, cpt_init_o=0, done_o=0, err_o=0; state IDLE; FIFO empty.
- Reset asserted mid-message discards all buffered blocks immediately (asynchronously).
- start_i at cycle N: cpt_en_o=cpt_init_o=1 at N+1; data_ready_o=1 from N+2.
- Latency: a block accepted at cycle N into an empty FIFO is on bloc_o with bloc_valid_o=1 at N+1.
- A pop at cycle N exposes the next FIFO entry at N+1.
- Sustained throughput: 1 block per cycle when bloc_ack_i is held high.
- err_o is set the cycle after the offending transfer. It is held through IDLE until the next start_i or reset.

## Test plan
- Nominal 3-block message:
  - Stimulus: start_i; blocks 0xA..., 0xB..., 0xC... with last_i on the third; bloc_ack_i held high.
  - Required response: core sees the 3 blocks in order with bloc_last_o only on 0xC...; cpt_en_o pulses twice with no init; done_o pulses once.
- Backpressure:
  - Stimulus: bloc_ack_i=0 while 3 blocks are offered.
  - Required response: data_ready_o drops after 2 accepts; the third block is accepted only after the first pop; the data order is preserved.
- Overflow:
  - Stimulus: 4 blocks with last_i=0.
  - Required response: err_o=1 the cycle after the 4th transfer; the 4th block is tagged last; a 5th offered block is never accepted (data_ready_o stays 0).
- Restart mid-message:
  - Stimulus: start_i while 2 blocks are buffered.
  - Required response: bloc_valid_o=0 the next cycle; the INIT pulse appears; the old blocks never reach the core.
- Asynchronous reset:
  - Stimulus: assert resetb_i low between clock edges during RUN with occupancy 1.
  - Required response: all outputs 0 immediately; the FSM is in IDLE after release.
- Stray ack:
  - Stimulus: bloc_ack_i=1 with the FIFO empty in RUN.
  - Required response: no cpt_en_o pulse and no change of state.
